pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_stage.sv | 109 ++++++++++
 tb/tb_pipe_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage.sv
// Register-slice pipeline stage with a skid buffer, plus stall/bubble hazard hooks.
// down_* is driven only from registers; only stall reaches up_tready combinationally.
module pipe_stage #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             up_tvalid,
   output logic             up_tready,
   input  logic [WIDTH-1:0] up_tdata,
   output logic             down_tvalid,
   input  logic             down_tready,
   output logic [WIDTH-1:0] down_tdata,
   input  logic             stall,
   input  logic             bubble,
   output logic [15:0]      bubble_count,
   output logic [15:0]      stall_count
);

   localparam int unsigned CW = 16;

   logic             m_valid_q, m_valid_d;
   logic             s_valid_q, s_valid_d;
   logic [WIDTH-1:0] m_data_q,  m_data_d;
   logic [WIDTH-1:0] s_data_q,  s_data_d;
   logic [CW-1:0]    bubble_count_q, bubble_count_d;
   logic [CW-1:0]    stall_count_q,  stall_count_d;

   logic accept;
   logic drain;
   logic keep;

   assign up_tready = resetn & ~s_valid_q & ~stall;
   assign accept    = up_tvalid & up_tready;
   assign drain     = m_valid_q & down_tready;
   assign keep      = accept & ~bubble;

   // State and counter registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_valid_q      <= 1'b0;
         s_valid_q      <= 1'b0;
         m_data_q       <= '0;
         s_data_q       <= '0;
         bubble_count_q <= '0;
         stall_count_q  <= '0;
      end else begin
         m_valid_q      <= m_valid_d;
         s_valid_q      <= s_valid_d;
         m_data_q       <= m_data_d;
         s_data_q       <= s_data_d;
         bubble_count_q <= bubble_count_d;
         stall_count_q  <= stall_count_d;
      end
   end

   // Next state: EMPTY={0,0}, ONE={1,0}, FULL={1,1}
   always_comb begin
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      m_data_d  = m_data_q;
      s_data_d  = s_data_q;
      unique case ({m_valid_q, s_valid_q})
         2'b00: begin
            if (keep) begin
               m_valid_d = 1'b1;
               m_data_d  = up_tdata;
            end
         end
         2'b10: begin
            if (keep && drain) begin
               m_data_d = up_tdata;
            end else if (keep) begin
               s_valid_d = 1'b1;
               s_data_d  = up_tdata;
            end else if (drain) begin
               m_valid_d = 1'b0;
            end
         end
         2'b11: begin
            if (drain) begin
               s_valid_d = 1'b0;
               m_data_d  = s_data_q;
            end
         end
         default: begin
            // Unreachable skid-only state: fall back to EMPTY
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
         end
      endcase
   end

   // Saturating hazard counters
   always_comb begin
      bubble_count_d = bubble_count_q;
      stall_count_d  = stall_count_q;
      if (accept && bubble && (bubble_count_q != {CW{1'b1}}))
         bubble_count_d = bubble_count_q + CW'(1);
      if (stall && up_tvalid && (stall_count_q != {CW{1'b1}}))
         stall_count_d = stall_count_q + CW'(1);
   end

   assign down_tvalid  = m_valid_q;
   assign down_tdata   = m_data_q;
   assign bubble_count = bubble_count_q;
   assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: streaming, backpressure, stall, bubble, reset, saturation.
module tb_pipe_stage;

   logic        clk;
   logic        resetn;
   logic        up_tvalid;
   logic        up_tready;
   logic [31:0] up_tdata;
   logic        down_tvalid;
   logic        down_tready;
   logic [31:0] down_tdata;
   logic        stall;
   logic        bubble;
   logic [15:0] bubble_count;
   logic [15:0] stall_count;

   int checks;
   int failures;

   pipe_stage #(.WIDTH(32)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .up_tvalid    (up_tvalid),
      .up_tready    (up_tready),
      .up_tdata     (up_tdata),
      .down_tvalid  (down_tvalid),
      .down_tready  (down_tready),
      .down_tdata   (down_tdata),
      .stall        (stall),
      .bubble       (bubble),
      .bubble_count (bubble_count),
      .stall_count  (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge so registered outputs are settled
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      resetn      = 1'b0;
      up_tvalid   = 1'b0;
      up_tdata    = 32'h0;
      down_tready = 1'b1;
      stall       = 1'b0;
      bubble      = 1'b0;

      // Reset state
      #1;
      chk("rst_dvalid", 32'(down_tvalid), 32'd0);
      chk("rst_uready", 32'(up_tready), 32'd0);
      chk("rst_bcnt", 32'(bubble_count), 32'd0);
      chk("rst_scnt", 32'(stall_count), 32'd0);
      step();
      step();
      resetn = 1'b1;
      #1;
      chk("post_rst_uready", 32'(up_tready), 32'd1);

      // Streaming 1,2,3,4 at one beat per cycle
      up_tvalid = 1'b1;
      up_tdata  = 32'd1;
      step();
      for (int i = 1; i <= 4; i++) begin
         chk("stream_dvalid", 32'(down_tvalid), 32'd1);
         chk("stream_data", down_tdata, 32'(i));
         if (i < 4) up_tdata = 32'(i + 1);
         else       up_tvalid = 1'b0;
         #1;
         chk("stream_uready", 32'(up_tready), 32'd1);
         step();
      end
      chk("stream_empty", 32'(down_tvalid), 32'd0);

      // Backpressure: A,B into a blocked stage fills the skid
      down_tready = 1'b0;
      up_tvalid   = 1'b1;
      up_tdata    = 32'h0000_000A;
      step();
      up_tdata = 32'h0000_000B;
      step();
      up_tvalid = 1'b0;
      #1;
      chk("bp_full_uready", 32'(up_tready), 32'd0);
      chk("bp_full_data", down_tdata, 32'h0000_000A);
      step();
      chk("bp_hold_dvalid", 32'(down_tvalid), 32'd1);
      chk("bp_hold_data", down_tdata, 32'h0000_000A);
      down_tready = 1'b1;
      step();
      chk("bp_second_data", down_tdata, 32'h0000_000B);
      chk("bp_uready", 32'(up_tready), 32'd1);
      step();
      chk("bp_empty", 32'(down_tvalid), 32'd0);

      // Stall: three stalled cycles with a held beat that still drains
      down_tready = 1'b0;
      up_tvalid   = 1'b1;
      up_tdata    = 32'h77;
      step();
      stall    = 1'b1;
      up_tdata = 32'h88;
      #1;
      chk("stall_uready", 32'(up_tready), 32'd0);
      step();
      step();
      step();
      chk("stall_count3", 32'(stall_count), 32'd3);
      chk("stall_held_data", down_tdata, 32'h77);
      up_tvalid   = 1'b0;
      down_tready = 1'b1;
      step();
      chk("stall_drained", 32'(down_tvalid), 32'd0);
      chk("stall_count_hold", 32'(stall_count), 32'd3);
      stall = 1'b0;

      // Bubble discards the middle beat
      up_tvalid = 1'b1;
      up_tdata  = 32'h10;
      step();
      chk("bub_first", down_tdata, 32'h10);
      up_tdata = 32'h20;
      bubble   = 1'b1;
      step();
      chk("bub_dropped", 32'(down_tvalid), 32'd0);
      chk("bub_count1", 32'(bubble_count), 32'd1);
      up_tdata = 32'h30;
      bubble   = 1'b0;
      step();
      chk("bub_third_valid", 32'(down_tvalid), 32'd1);
      chk("bub_third", down_tdata, 32'h30);
      up_tvalid = 1'b0;
      bubble    = 1'b1;
      step();
      chk("bub_idle_count", 32'(bubble_count), 32'd1);
      chk("bub_idle_empty", 32'(down_tvalid), 32'd0);
      bubble = 1'b0;

      // Reset while FULL
      down_tready = 1'b0;
      up_tvalid   = 1'b1;
      up_tdata    = 32'h1;
      step();
      up_tdata = 32'h2;
      step();
      up_tvalid = 1'b0;
      resetn    = 1'b0;
      #1;
      chk("mrst_dvalid", 32'(down_tvalid), 32'd0);
      chk("mrst_uready", 32'(up_tready), 32'd0);
      chk("mrst_bcnt", 32'(bubble_count), 32'd0);
      chk("mrst_scnt", 32'(stall_count), 32'd0);
      step();
      resetn      = 1'b1;
      down_tready = 1'b1;
      up_tvalid   = 1'b1;
      up_tdata    = 32'h55;
      step();
      chk("mrst_beat_valid", 32'(down_tvalid), 32'd1);
      chk("mrst_beat", down_tdata, 32'h55);
      up_tvalid = 1'b0;
      step();
      chk("mrst_only_one", 32'(down_tvalid), 32'd0);

      // Bubble counter saturation after 65537 bubbled accepts
      up_tvalid = 1'b1;
      bubble    = 1'b1;
      up_tdata  = 32'hDEAD;
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_fffe", 32'(bubble_count), 32'h0000_FFFE);
      repeat (3) @(posedge clk);
      #1;
      chk("sat_ffff", 32'(bubble_count), 32'h0000_FFFF);
      chk("sat_empty", 32'(down_tvalid), 32'd0);
      up_tvalid = 1'b0;
      bubble    = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
